// File: rtl/control_sequencer_if.sv
// Strobe bundle between the hardwired control sequencer and the Datapath.
// The sequencer is the master; the datapath (or a bench) takes the slave view.
interface control_sequencer_if;
  logic        Run;
  logic [31:0] IR;

  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        Zin;
  logic        Zlowout;
  logic        Zhiout;
  logic        PCin;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        HIin;
  logic        LOin;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [4:0]  IRout;
  logic        Halted;
  logic        Illegal;
  logic [3:0]  Tstate;

  modport master (
    input  Run, IR,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read,
           MDRin, MDRout, IRin, Yin, HIin, LOin,
           Rout, Rin, IRout, Halted, Illegal, Tstate
  );

  modport slave (
    output Run, IR,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read,
           MDRin, MDRout, IRin, Yin, HIin, LOin,
           Rout, Rin, IRout, Halted, Illegal, Tstate
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) then execute (T3-T6) for
// register-register ALU instructions, one state per clock.
module control_sequencer (
  input  logic                clk,
  input  logic                Clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11011;
  localparam logic [4:0] OP_HALT = 5'b11100;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_ALU;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  state_e     state_q;
  state_e     state_d;
  state_e     end_of_instr;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  op_class_e  op_class;
  logic       unused_ir_low;

  assign opcode        = bus.IR[31:27];
  assign ra            = bus.IR[26:23];
  assign rb            = bus.IR[22:19];
  assign rc            = bus.IR[18:15];
  assign op_class      = classify(opcode);
  assign unused_ir_low = ^bus.IR[14:0];

  // Finishing an instruction chains straight into the next fetch while Run holds.
  assign end_of_instr = bus.Run ? S_T0 : S_IDLE;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and synthesis cannot infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (op_class)
          CLS_ALU, CLS_MULDIV, CLS_UNARY: state_d = S_T4;
          CLS_HALT:                       state_d = S_HALT;
          default:                        state_d = end_of_instr;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (op_class == CLS_MULDIV) ? S_T6 : end_of_instr;
      S_T6:   state_d = end_of_instr;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge value of its inputs regardless of evaluation order.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Strobes are a pure decode of the registered state, so Clear zeroes them
  // as soon as the state flop resets.
  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Zhiout  = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.HIin    = 1'b0;
    bus.LOin    = 1'b0;
    bus.Rout    = 16'h0000;
    bus.Rin     = 16'h0000;
    bus.IRout   = 5'b00000;
    bus.Halted  = 1'b0;
    bus.Illegal = 1'b0;

    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_ALU, CLS_MULDIV: begin
            bus.Rout = reg_onehot(rb);
            bus.Yin  = 1'b1;
          end
          CLS_ILLEGAL: bus.Illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        // Binary ops take the second operand from Rc; unary ops use Rb alone.
        case (op_class)
          CLS_ALU, CLS_MULDIV: begin
            bus.Rout  = reg_onehot(rc);
            bus.IRout = opcode;
            bus.Zin   = 1'b1;
          end
          CLS_UNARY: begin
            bus.Rout  = reg_onehot(rb);
            bus.IRout = opcode;
            bus.Zin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) bus.LOin = 1'b1;
        else                        bus.Rin  = reg_onehot(ra);
      end
      S_T6: begin
        bus.Zhiout = 1'b1;
        bus.HIin   = 1'b1;
      end
      S_HALT: bus.Halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.Tstate = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level model
// (step index within an instruction plus per-class step tables) checked every cycle.
module tb_control_sequencer;

  typedef enum int {M_IDLE, M_RUN, M_HALT} mphase_e;

  typedef struct packed {
    logic [3:0]  tstate;
    logic [13:0] strb;   // PCout MARin IncPC Zin Zlowout Zhiout PCin Read MDRin MDRout IRin Yin HIin LOin
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  irout;
    logic        halted;
    logic        illegal;
  } vec_t;

  logic clk;
  logic Clear;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clk   (clk),
    .Clear (Clear),
    .bus   (bus_if.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  mphase_e     m_phase;
  int          m_k;
  logic [31:0] m_word;
  logic [31:0] word_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0 alu, 1 mul/div, 2 unary, 3 nop, 4 halt, 5 illegal
  function automatic int op_cls(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return 0;
      5'd15, 5'd16: return 1;
      5'd17, 5'd18: return 2;
      5'd27:        return 3;
      5'd28:        return 4;
      default:      return 5;
    endcase
  endfunction

  // Cycles from T0 to the last execute step inclusive.
  function automatic int instr_len(input logic [31:0] w);
    case (op_cls(w[31:27]))
      0, 2:    return 6;
      1:       return 7;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t model_vec(input mphase_e ph, input int k, input logic [31:0] w);
    vec_t v;
    logic pc = 0, mar = 0, inc = 0, zin = 0, zlo = 0, zhi = 0, pcin = 0;
    logic rd = 0, mdrin = 0, mdrout = 0, irin = 0, yin = 0, hiin = 0, loin = 0;
    int c;
    v = '0;
    c = op_cls(w[31:27]);
    if (ph == M_HALT) begin
      v.tstate = 4'd15;
      v.halted = 1'b1;
    end else if (ph == M_RUN) begin
      v.tstate = 4'(k + 1);
      case (k)
        0: begin pc = 1; mar = 1; inc = 1; zin = 1; end
        1: begin zlo = 1; pcin = 1; rd = 1; mdrin = 1; end
        2: begin mdrout = 1; irin = 1; end
        3: begin
          if (c == 0 || c == 1) begin v.rout = 16'h1 << w[22:19]; yin = 1; end
          if (c == 5) v.illegal = 1'b1;
        end
        4: begin
          v.rout  = 16'h1 << ((c == 2) ? w[22:19] : w[18:15]);
          v.irout = w[31:27];
          zin     = 1;
        end
        5: begin
          zlo = 1;
          if (c == 1) loin = 1;
          else        v.rin = 16'h1 << w[26:23];
        end
        6: begin zhi = 1; hiin = 1; end
        default: ;
      endcase
    end
    v.strb = {pc, mar, inc, zin, zlo, zhi, pcin, rd, mdrin, mdrout, irin, yin, hiin, loin};
    return v;
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    v.tstate  = bus_if.Tstate;
    v.strb    = {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.Zin, bus_if.Zlowout,
                 bus_if.Zhiout, bus_if.PCin, bus_if.Read, bus_if.MDRin, bus_if.MDRout,
                 bus_if.IRin, bus_if.Yin, bus_if.HIin, bus_if.LOin};
    v.rout    = bus_if.Rout;
    v.rin     = bus_if.Rin;
    v.irout   = bus_if.IRout;
    v.halted  = bus_if.Halted;
    v.illegal = bus_if.Illegal;
    return v;
  endfunction

  // Random non-halt instruction word, biased towards legal opcodes.
  function automatic logic [31:0] rand_word();
    logic [4:0] legal[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                              5'd15, 5'd16, 5'd17, 5'd18, 5'd27};
    logic [4:0]  op;
    logic [31:0] w;
    if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 12)];
    else                           op = 5'($urandom_range(0, 31));
    if (op == 5'd28) op = 5'd27;
    w = $urandom;
    w[31:27] = op;
    return w;
  endfunction

  // Instruction-level reference: advance one step per clock.
  always @(posedge clk or posedge Clear) begin
    if (Clear) begin
      m_phase <= M_IDLE;
      m_k     <= 0;
      m_word  <= '0;
    end else begin
      case (m_phase)
        M_IDLE: if (bus_if.Run) begin m_phase <= M_RUN; m_k <= 0; end
        M_RUN: begin
          if (m_k == 3) m_word <= bus_if.IR;
          if (m_k < 3)                                  m_k <= m_k + 1;
          else if (m_k == 3 && op_cls(bus_if.IR[31:27]) == 4) m_phase <= M_HALT;
          else if (m_k + 1 < instr_len(m_k == 3 ? bus_if.IR : m_word)) m_k <= m_k + 1;
          else if (bus_if.Run)                          m_k <= 0;
          else                                          m_phase <= M_IDLE;
        end
        default: ;
      endcase
    end
  end

  // IR is scrambled during fetch/idle; the next program word is presented in T3
  // and held through execute.
  always @(posedge clk) begin
    #2;
    if (m_phase == M_RUN && m_k == 3) begin
      if (word_q.size() > 0) bus_if.IR = word_q.pop_front();
      else                   bus_if.IR = rand_word();
    end else if (m_phase == M_IDLE || (m_phase == M_RUN && m_k < 3)) begin
      bus_if.IR = $urandom;
    end
  end

  always @(negedge clk) begin
    vec_t e, g;
    e = model_vec(m_phase, m_k, (m_k == 3) ? bus_if.IR : m_word);
    g = dut_vec();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL cycle_compare t=%0t got=%h exp=%h", $time, g, e);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic wait_k(input int target, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_phase == M_RUN && m_k == target) && n < 60);
    if (!(m_phase == M_RUN && m_k == target)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout waiting for step %0d", name, target);
    end
  endtask

  initial begin
    int n;
    Clear     = 1'b1;
    bus_if.Run = 1'b0;
    bus_if.IR  = '0;
    repeat (2) @(negedge clk);
    check("reset_all_zero", 64'(dut_vec()), 64'h0);
    #1 Clear = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_without_run", 64'(bus_if.Tstate), 64'd0);

    word_q.push_back({5'b00110, 4'd4, 4'd2, 4'd1, 15'd0});   // shl R4,R2,R1
    word_q.push_back({5'b01111, 4'd1, 4'd3, 4'd5, 15'd0});   // mul R3,R5
    word_q.push_back({5'b10010, 4'd7, 4'd6, 4'd0, 15'd0});   // not R7,R6
    word_q.push_back({5'b11111, 27'h5a5a5a5});               // illegal
    word_q.push_back({5'b11011, 27'h1234567});               // nop
    word_q.push_back({5'b00011, 4'd9, 4'd1, 4'd2, 15'd0});   // add R9,R1,R2
    #1 bus_if.Run = 1'b1;

    wait_k(3, "shl_t3");
    check("shl_t3_rout", 64'(bus_if.Rout), 64'h0004);
    check("shl_t3_yin",  64'(bus_if.Yin),  64'd1);
    wait_k(4, "shl_t4");
    check("shl_t4_rout",  64'(bus_if.Rout),  64'h0002);
    check("shl_t4_irout", 64'(bus_if.IRout), 64'h06);
    wait_k(5, "shl_t5");
    check("shl_t5_rin", 64'(bus_if.Rin), 64'h0010);
    @(negedge clk);
    check("shl_then_t0", 64'(bus_if.Tstate), 64'd1);

    wait_k(4, "mul_t4");
    check("mul_t4_rout",  64'(bus_if.Rout),  64'h0020);
    check("mul_t4_irout", 64'(bus_if.IRout), 64'h0f);
    wait_k(5, "mul_t5");
    check("mul_t5_lo", 64'({bus_if.Zlowout, bus_if.LOin, bus_if.Rin}), 64'h30000);
    wait_k(6, "mul_t6");
    check("mul_t6_hi", 64'({bus_if.Zhiout, bus_if.HIin, bus_if.Rin}), 64'h30000);

    wait_k(3, "not_t3");
    check("not_t3_quiet", 64'({bus_if.Yin, bus_if.Rout}), 64'h0);
    wait_k(4, "not_t4");
    check("not_t4_rout",  64'(bus_if.Rout),  64'h0040);
    check("not_t4_irout", 64'(bus_if.IRout), 64'h12);
    wait_k(5, "not_t5");
    check("not_t5_rin", 64'(bus_if.Rin), 64'h0080);

    wait_k(3, "ill_t3");
    check("ill_pulse", 64'(bus_if.Illegal), 64'd1);
    @(negedge clk);
    check("ill_pulse_end", 64'({bus_if.Illegal, bus_if.Tstate}), 64'h01);

    wait_k(3, "nop_t3");
    check("nop_t3", 64'(bus_if.Tstate), 64'd4);
    @(negedge clk);
    check("nop_then_t0", 64'(bus_if.Tstate), 64'd1);

    wait_k(2, "add_t2");
    #1 bus_if.Run = 1'b0;
    wait_k(5, "add_t5");
    check("add_t5_rin", 64'(bus_if.Rin), 64'h0200);
    repeat (3) @(negedge clk);
    check("add_run_low_idle", 64'(bus_if.Tstate), 64'd0);

    // Asynchronous Clear in the middle of T4.
    word_q.push_back({5'b00100, 4'd3, 4'd4, 4'd5, 15'd0});
    #1 bus_if.Run = 1'b1;
    wait_k(4, "clr_t4");
    #1 Clear = 1'b1;
    #1 check("clear_async", 64'(dut_vec()), 64'h0);
    @(negedge clk);
    #1 begin Clear = 1'b0; bus_if.Run = 1'b0; end
    repeat (3) @(negedge clk);
    check("clear_then_idle", 64'(bus_if.Tstate), 64'd0);

    repeat (3000) begin
      @(negedge clk);
      #1 bus_if.Run = ($urandom_range(0, 99) < 85);
    end

    word_q.delete();
    word_q.push_back({5'b11100, 27'h0});
    bus_if.Run = 1'b1;
    n = 0;
    while (m_phase != M_HALT && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 64'(m_phase == M_HALT), 64'd1);
    repeat (10) @(negedge clk);
    check("halt_sticky", 64'({bus_if.Halted, bus_if.Tstate}), 64'h1f);
    #1 Clear = 1'b1;
    #1 check("halt_clear", 64'({bus_if.Halted, bus_if.Tstate}), 64'h00);
    @(negedge clk);
    #1 Clear = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the strobe inputs of the existing Datapath block. It steps a Moore state machine through instruction fetch (T0–T2) and execute (T3–T6) for register–register ALU instructions, decoding the instruction word returned by the datapath's IR. It replaces hand-sequenced strobes with cycle-exact, one-state-per-clock control.

## Interface
Parameters:
- none (opcode map and field positions fixed below)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- Clear  in  1  asynchronous, active-high reset; forces state IDLE and all outputs to reset values
- Run  in  1  level; high allows fetch to start from IDLE or continue after an instruction
- IR  in  32  instruction register contents from Datapath; [31:27] opcode, [26:23] Ra (dest), [22:19] Rb, [18:15] Rc
- PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes
- Rout  out  16  one-hot register-to-bus select (bit n = Rnout)
- Rin  out  16  one-hot bus-to-register load (bit n = Rnin)
- IRout  out  5  ALU operation select
- Halted  out  1  high while in HALT
- Illegal  out  1  one-cycle pulse on an undefined opcode
- Tstate  out  4  current state code, debug

## Operation
- Opcodes: 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or, 01111 mul, 10000 div, 10001 neg, 10010 not, 11011 nop, 11100 halt. All others are illegal.
- States and codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=15.
- IDLE: all strobes 0. If Run=1, go to T0; otherwise stay.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Go to T2.
- T2: MDRout, IRin. Go to T3. IR is valid from T3 onward.
- T3 decode:
  - binary ops (add…or, mul, div): Rout[Rb], Yin; go to T4.
  - unary ops (neg, not): no strobes; go to T4.
  - nop: no strobes; end of instruction.
  - halt: go to HALT.
  - illegal: Illegal=1; end of instruction.
- T4:
  - binary ops: Rout[Rc], IRout=opcode, Zin.
  - unary ops: Rout[Rb], IRout=opcode, Zin.
  - Go to T5.
- T5:
  - mul/div: Zlowout, LOin; go to T6.
  - all others: Zlowout, Rin[Ra]; end of instruction.
- T6 (mul/div only): Zhiout, HIin; end of instruction.
- End of instruction: next state is T0 if Run=1, else IDLE.
- HALT: Halted=1, all strobes 0. Only Clear exits HALT; Run is ignored.
- Outputs are decoded combinationally from the registered state and IR[31:15].
- Rout and Rin are zero or one-hot, never multi-hot.
- At most one bus driver is active in any state: PCout, Zlowout, Zhiout, MDRout, or a single Rout bit.
- IRout is 0 in every state except T4.
- Ra=0 is a legal destination; no R0 special casing here.

## Timing
- Reset values: state IDLE, Tstate=0, every strobe/Rout/Rin/IRout/Halted/Illegal = 0.
- Clear is asynchronous: it takes effect without a clock edge and aborts any state immediately, including mid-fetch or mid-T6. The first clock edge after Clear falls evaluates IDLE.
- Latency from IDLE with Run=1: T0 on the next edge.
- Cycles per instruction, counted T0 to last execute state inclusive:
  - ALU / unary: 6
  - mul/div: 7
  - nop / illegal: 4
  - halt: 4 to reach HALT
- Run falling mid-instruction does not abort; the instruction completes, then the sequencer enters IDLE.
- Back-to-back instructions: T5/T6 is followed directly by T0 with no bubble.
- IR changing in T0–T2 has no effect on outputs; opcode/register fields are used only in T3–T6.

## Test plan
- Reset: assert Clear mid-T4 -> all outputs 0 and Tstate=0 immediately, without a clock edge; after release with Run=0, the sequencer stays in IDLE.
- shl: Run=1, IR={00110, Ra=4, Rb=2, Rc=1, 0} -> T3 Rout=0x0004, Yin; T4 Rout=0x0002, IRout=00110, Zin; T5 Zlowout, Rin=0x0010; then T0.
- mul: IR opcode 01111, Rb=3, Rc=5 -> T4 Rout=0x0020, IRout=01111; T5 Zlowout+LOin; T6 Zhiout+HIin; Rin stays 0 throughout.
- not: opcode 10010, Ra=7, Rb=6 -> T3 no strobes; T4 Rout=0x0040, IRout=10010; T5 Rin=0x0080.
- Illegal/nop/halt:
  - opcode 11111 -> Illegal pulses for 1 cycle in T3; next T0.
  - opcode 11100 -> Halted=1 and stays high with Run=1 for 10 cycles until Clear.
- Run deassert: drop Run during T2 of an add -> add completes through T5, then IDLE; no T0 until Run=1 again.
